// File: rtl/rv_bus_arb.sv
// Shared memory-bus arbiter between instruction fetch and data ports.
// Data normally wins; a saturating starvation counter forces a fetch grant.
module rv_bus_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_fetch_req,
  input  logic [ADDR_W-1:0]   i_fetch_addr,
  output logic                o_fetch_ack,
  output logic [DATA_W-1:0]   o_fetch_rdata,
  output logic                o_fetch_err,
  input  logic                i_data_req,
  input  logic                i_data_we,
  input  logic [DATA_W/8-1:0] i_data_sel,
  input  logic [ADDR_W-1:0]   i_data_addr,
  input  logic [DATA_W-1:0]   i_data_wdata,
  output logic                o_data_ack,
  output logic [DATA_W-1:0]   o_data_rdata,
  output logic                o_data_err,
  output logic                o_bus_cyc,
  output logic                o_bus_we,
  output logic [DATA_W/8-1:0] o_bus_sel,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  input  logic                i_bus_ack,
  input  logic                i_bus_err,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_bus_owner
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             data_win_s;

  // Grant decision and starvation-counter next state, evaluated only in IDLE.
  always_comb begin
    data_win_s = i_data_req && !(i_fetch_req && (starve_q == LIMIT));
    starve_d   = starve_q;
    if (state_q == S_IDLE) begin
      if (!i_fetch_req) begin
        starve_d = '0;
      end else if (data_win_s) begin
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
      end else begin
        starve_d = '0;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbitration FSM with all bus and response outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      starve_q      <= '0;
      o_bus_owner   <= 1'b0;
      o_bus_cyc     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_sel     <= '0;
      o_bus_addr    <= '0;
      o_bus_wdata   <= '0;
      o_fetch_ack   <= 1'b0;
      o_fetch_err   <= 1'b0;
      o_fetch_rdata <= '0;
      o_data_ack    <= 1'b0;
      o_data_err    <= 1'b0;
      o_data_rdata  <= '0;
    end else begin
      starve_q    <= starve_d;
      o_fetch_ack <= 1'b0;
      o_fetch_err <= 1'b0;
      o_data_ack  <= 1'b0;
      o_data_err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_win_s) begin
            state_q     <= S_DATA;
            o_bus_owner <= 1'b1;
            o_bus_cyc   <= 1'b1;
            o_bus_we    <= i_data_we;
            o_bus_sel   <= i_data_sel;
            o_bus_addr  <= i_data_addr;
            o_bus_wdata <= i_data_wdata;
          end else if (i_fetch_req) begin
            state_q     <= S_FETCH;
            o_bus_owner <= 1'b0;
            o_bus_cyc   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= {SEL_W{1'b1}};
            o_bus_addr  <= i_fetch_addr;
          end else begin
            state_q <= S_IDLE;
          end
        end
        // The ack pulse is launched on the completing edge so it is visible
        // throughout RESP, one cycle after the slave completion.
        S_FETCH, S_DATA: begin
          if (i_bus_ack || i_bus_err) begin
            state_q   <= S_RESP;
            o_bus_cyc <= 1'b0;
            if (state_q == S_DATA) begin
              o_data_ack   <= 1'b1;
              o_data_err   <= i_bus_err;
              o_data_rdata <= i_bus_rdata;
            end else begin
              o_fetch_ack   <= 1'b1;
              o_fetch_err   <= i_bus_err;
              o_fetch_rdata <= i_bus_rdata;
            end
          end else begin
            state_q <= state_q;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          o_bus_cyc <= 1'b0;
        end
      endcase
    end
  end

endmodule
